ctrl_elastic_pipe: RTL and testbench

- Parametrised elastic pipeline that replaces the hand-written pipe1/pipe2 register banks between the sensor interfaces, the balance controller and the motor drive.
- Provides DEPTH valid/ready stages of DATA_W payload with full throughput and registered ready.
- Adds behaviour the fixed banks lack: backpressure, synchronous flush (used on pwr_up loss or rider_off), occupancy reporting, and a saturating drop counter for non-stallable sources such as the inertial interface.

---
 rtl/ctrl_pipe_pkg.sv | 20 ++
 rtl/skid_stage.sv | 74 +++++++
 rtl/ctrl_elastic_pipe.sv | 116 +++++++++++
 tb/tb_ctrl_elastic_pipe.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared types and sizing helpers for the control-path elastic pipeline.
// Imported by the pipeline top and by callers that pack the Segway payload.
package ctrl_pipe_pkg;

    localparam int DROP_CNT_W = 8;

    typedef struct packed {
        logic [15:0] ptch;
        logic [15:0] ptch_rt;
        logic [11:0] steer_pot;
        logic        en_steer;
        logic        pwr_up;
    } seg_payload_t;

    // Occupancy ranges over 0..2*depth, so it needs room for 2*depth+1 values.
    function automatic int occ_w(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/skid_stage.sv
// One valid/ready stage built from a main register and a skid register.
// Upstream ready comes straight from the skid flag, so it is always registered.
module skid_stage #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_vld,
    output logic              up_rdy,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_vld,
    input  logic              dn_rdy,
    output logic [DATA_W-1:0] dn_data
);

    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_full_q, skid_full_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              up_xfer;
    logic              drain;

    assign up_rdy  = ~skid_full_q;
    assign dn_vld  = main_vld_q;
    assign dn_data = main_data_q;
    assign up_xfer = up_vld & ~skid_full_q;
    assign drain   = main_vld_q & dn_rdy;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_vld_d  = 1'b0;
            skid_full_d = 1'b0;
        end else if (drain) begin
            // The skid can only be full while upstream is held off, so it has priority.
            if (skid_full_q) begin
                main_data_d = skid_data_q;
                skid_full_d = 1'b0;
            end else if (up_xfer) begin
                main_data_d = up_data;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (up_xfer) begin
            if (main_vld_q) begin
                skid_data_d = up_data;
                skid_full_d = 1'b1;
            end else begin
                main_data_d = up_data;
                main_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q  <= 1'b0;
            main_data_q <= RST_DATA;
            skid_full_q <= 1'b0;
            skid_data_q <= RST_DATA;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: rtl/ctrl_elastic_pipe.sv
// Elastic DEPTH-stage valid/ready pipeline between sensor, balance and drive blocks,
// with synchronous flush, occupancy reporting and a saturating drop counter.
module ctrl_elastic_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [DATA_W-1:0]       out_data,
    output logic [occ_w(DEPTH)-1:0] occupancy,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam int                    OCC_W    = occ_w(DEPTH);
    localparam logic [OCC_W-1:0]      OCC_ONE  = OCC_W'(1);
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    logic [DEPTH-1:0]             stg_vld;
    logic [DEPTH-1:0]             stg_rdy;
    logic [DEPTH-1:0][DATA_W-1:0] stg_data;

    logic                  in_xfer, out_xfer, drop_evt;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic              up_vld;
            logic              dn_rdy;
            logic [DATA_W-1:0] up_data;

            if (gi == 0) begin : g_head
                // A flushed input must never enter the chain.
                assign up_vld  = in_vld & ~flush;
                assign up_data = in_data;
            end else begin : g_link
                assign up_vld  = stg_vld[gi-1];
                assign up_data = stg_data[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_tail
                assign dn_rdy = out_rdy;
            end else begin : g_mid
                assign dn_rdy = stg_rdy[gi+1];
            end

            skid_stage #(
                .DATA_W   (DATA_W),
                .RST_DATA (RST_DATA)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .flush   (flush),
                .up_vld  (up_vld),
                .up_rdy  (stg_rdy[gi]),
                .up_data (up_data),
                .dn_vld  (stg_vld[gi]),
                .dn_rdy  (dn_rdy),
                .dn_data (stg_data[gi])
            );
        end
    endgenerate

    assign in_rdy    = stg_rdy[0];
    assign out_vld   = stg_vld[DEPTH-1];
    assign out_data  = stg_data[DEPTH-1];
    assign occupancy = occ_q;
    assign drop_cnt  = drop_q;

    assign in_xfer  = in_vld & in_rdy & ~flush;
    assign out_xfer = out_vld & out_rdy;
    assign drop_evt = in_vld & ~in_rdy & ~flush;

    // Tracking transfers keeps occupancy equal to the count of set valid/skid bits.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (drop_evt && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + DROP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= '0;
            drop_q <= '0;
        end else begin
            occ_q  <= occ_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_ctrl_elastic_pipe.sv
// Bench for ctrl_elastic_pipe: queue model on a DEPTH=2 instance checked every cycle,
// plus directed latency/capacity checks on DEPTH=1 and DEPTH=8 instances.
module tb_ctrl_elastic_pipe;

    localparam int D = 2;
    localparam logic [15:0] RSTD = 16'hBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_vld = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_rdy = 1'b0;
    logic        in_rdy, out_vld;
    logic [15:0] out_data;
    logic [2:0]  occupancy;
    logic [7:0]  drop_cnt;

    logic        x_in_vld = 1'b0;
    logic [15:0] x_in_data = '0;
    logic        x_out_rdy = 1'b0;
    logic        x1_in_rdy, x1_out_vld, x8_in_rdy, x8_out_vld;
    logic [15:0] x1_out_data, x8_out_data;
    logic [1:0]  x1_occ;
    logic [4:0]  x8_occ;
    logic [7:0]  x1_drop, x8_drop;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ctrl_elastic_pipe #(.DATA_W(16), .DEPTH(D), .RST_DATA(RSTD)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    ctrl_elastic_pipe #(.DATA_W(16), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_vld(x_in_vld), .in_rdy(x1_in_rdy), .in_data(x_in_data),
        .out_vld(x1_out_vld), .out_rdy(x_out_rdy), .out_data(x1_out_data),
        .occupancy(x1_occ), .drop_cnt(x1_drop)
    );

    ctrl_elastic_pipe #(.DATA_W(16), .DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_vld(x_in_vld), .in_rdy(x8_in_rdy), .in_data(x_in_data),
        .out_vld(x8_out_vld), .out_rdy(x_out_rdy), .out_data(x8_out_data),
        .occupancy(x8_occ), .drop_cnt(x8_drop)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: FIFO of accepted words, each visible no earlier than DEPTH-1 edges after its accepting edge.
    typedef struct { logic [15:0] d; int vis; } ent_t;
    ent_t       mq[$];
    int         cyc = 0;
    logic [7:0] m_drop = '0;

    function automatic bit m_vld();
        return (mq.size() != 0) && (mq[0].vis <= cyc);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_drop = '0;
            cyc = 0;
        end else begin
            bit pop;
            pop = m_vld() && out_rdy;
            cyc++;
            if (pop) void'(mq.pop_front());
            if (flush) begin
                mq.delete();
            end else if (in_vld) begin
                if (in_rdy) mq.push_back('{d: in_data, vis: cyc + D - 1});
                else if (m_drop != 8'hFF) m_drop++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && cmp_en) begin
            check("out_vld", out_vld, m_vld());
            if (m_vld()) check("out_data", out_data, mq[0].d);
            check("occupancy", occupancy, mq.size());
            check("drop_cnt", drop_cnt, m_drop);
            if (mq.size() <= D) check("in_rdy_room", in_rdy, 1);
            if (mq.size() == 2 * D) check("in_rdy_full", in_rdy, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc, acc1, acc8, lat1, lat8, n;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        cmp_en = 1'b1;
        check("rst_out_vld", out_vld, 0);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_occ", occupancy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_out_data", out_data, 16'hBEEF);

        // Streaming with the sink always ready.
        out_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_vld = 1'b1;
            in_data = i[15:0];
            tick();
            if (i == 1) check("lat_early", out_vld, 0);
            if (i == 2) begin
                check("lat_first_vld", out_vld, 1);
                check("lat_first_data", out_data, 16'h0001);
            end
            if (i == 8) check("steady_occ", occupancy, 2);
        end
        in_vld = 1'b0;
        repeat (4) tick();
        check("stream_empty", occupancy, 0);
        check("stream_drop", drop_cnt, 0);

        // Backpressure: fill until in_rdy drops.
        out_rdy = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_vld = 1'b1;
            in_data = 16'(16'h0100 + k);
            if (in_rdy) n_acc++;
            tick();
        end
        check("bp_accepts", n_acc, 4);
        check("bp_in_rdy", in_rdy, 0);
        check("bp_occ", occupancy, 4);
        check("bp_hold", out_data, 16'h0100);

        // Saturating drops from the full state.
        in_data = 16'hFFFF;
        repeat (300) tick();
        check("drop_sat", drop_cnt, 8'hFF);
        check("drop_hold", out_data, 16'h0100);
        check("drop_occ", occupancy, 4);

        in_vld = 1'b0;
        out_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("drain_vld", out_vld, 1);
            check("drain_data", out_data, 16'h0100 + j);
            tick();
        end
        check("drain_done", out_vld, 0);

        // Flush from occupancy 3 with a word offered on the flush cycle.
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_vld = 1'b1;
            in_data = 16'(16'h0200 + k);
            tick();
        end
        in_vld = 1'b0;
        check("pre_flush_occ", occupancy, 3);
        flush = 1'b1;
        in_vld = 1'b1;
        in_data = 16'hDEAD;
        tick();
        flush = 1'b0;
        in_vld = 1'b0;
        check("flush_occ", occupancy, 0);
        check("flush_vld", out_vld, 0);
        check("flush_rdy", in_rdy, 1);
        check("flush_drop", drop_cnt, 8'hFF);
        out_rdy = 1'b1;
        in_vld = 1'b1;
        in_data = 16'h0300;
        tick();
        in_vld = 1'b0;
        tick();
        check("post_flush_vld", out_vld, 1);
        check("post_flush_data", out_data, 16'h0300);
        tick();

        // Asynchronous reset mid-stream between edges.
        out_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_vld = 1'b1;
            in_data = 16'(16'h0400 + k);
            tick();
        end
        in_vld = 1'b0;
        check("pre_rst_occ", occupancy, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld", out_vld, 0);
        check("arst_data", out_data, 16'hBEEF);
        check("arst_rdy", in_rdy, 1);
        check("arst_occ", occupancy, 0);
        check("arst_drop", drop_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        out_rdy = 1'b1;
        in_vld = 1'b1;
        in_data = 16'h0500;
        tick();
        in_vld = 1'b0;
        check("rerun_early", out_vld, 0);
        tick();
        check("rerun_vld", out_vld, 1);
        check("rerun_data", out_data, 16'h0500);
        tick();

        // DEPTH=1 and DEPTH=8 latency.
        x_out_rdy = 1'b0;
        x_in_vld = 1'b1;
        x_in_data = 16'h1111;
        tick();
        x_in_vld = 1'b0;
        n = 1;
        lat1 = -1;
        lat8 = -1;
        if (x1_out_vld && lat1 < 0) lat1 = n;
        if (x8_out_vld && lat8 < 0) lat8 = n;
        for (int i = 0; i < 12; i++) begin
            tick();
            n++;
            if (x1_out_vld && lat1 < 0) lat1 = n;
            if (x8_out_vld && lat8 < 0) lat8 = n;
        end
        check("d1_latency", lat1, 1);
        check("d8_latency", lat8, 8);
        check("d8_lat_data", x8_out_data, 16'h1111);
        x_out_rdy = 1'b1;
        repeat (2) tick();
        x_out_rdy = 1'b0;
        check("d1_empty", x1_occ, 0);
        check("d8_empty", x8_occ, 0);

        // DEPTH=1 and DEPTH=8 capacity.
        acc1 = 0;
        acc8 = 0;
        for (int k = 0; k < 40; k++) begin
            x_in_vld = 1'b1;
            x_in_data = 16'(16'h0600 + k);
            if (x1_in_rdy) acc1++;
            if (x8_in_rdy) acc8++;
            tick();
        end
        x_in_vld = 1'b0;
        check("d1_capacity", acc1, 2);
        check("d8_capacity", acc8, 16);
        check("d1_full_rdy", x1_in_rdy, 0);
        check("d8_full_rdy", x8_in_rdy, 0);
        check("d1_full_occ", x1_occ, 2);
        check("d8_full_occ", x8_occ, 16);
        check("d1_drops", x1_drop, 38);
        check("d8_drops", x8_drop, 24);
        x_out_rdy = 1'b1;
        for (int j = 0; j < 16; j++) begin
            if (j < 2) begin
                check("d1_order_vld", x1_out_vld, 1);
                check("d1_order_data", x1_out_data, 16'h0600 + j);
            end
            check("d8_order_vld", x8_out_vld, 1);
            check("d8_order_data", x8_out_data, 16'h0600 + j);
            tick();
        end
        check("d8_drained", x8_out_vld, 0);
        check("d1_drained", x1_out_vld, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
